fpu_wb_collector: RTL and testbench
===================================

# fpu_wb_collector

Result-side counterpart of the exec-stage FPU issue interface. Each FPU unit (fadd, fsub, fmul, fdiv, fsqrt, ftoi, itof, for both the upper and lower slots) returns a result word, destination register and valid flag at its own fixed latency. This block buffers those results, arbitrates them onto the two register-file write ports (upper/lower), and raises a stall toward issue when buffered results back up.

## Interface
- N_SRC, 14, number of FPU result channels; index 2k is upper slot, 2k+1 lower slot of unit k
- FDEPTH, 2, per-source FIFO depth (power of two, ≥2)
- STALL_THRESH, 4, total buffered entries at or above which stall_out asserts
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- src_valid  in  N_SRC  result present on channel i this cycle (unit's rt_flag)
- src_rt  in  5*N_SRC  destination register, channel i at [5i+4:5i]
- src_data  in  32*N_SRC  result word, channel i at [32i+31:32i]
- u_wb_valid  out  1  upper write port valid
- u_wb_rt  out  5  upper write destination
- u_wb_data  out  32  upper write data
- l_wb_valid  out  1  lower write port valid
- l_wb_rt  out  5  lower write destination
- l_wb_data  out  32  lower write data
- stall_out  out  1  registered backpressure toward issue/exec interlock
- occupancy  out  $clog2(N_SRC*FDEPTH+1)  total buffered entries, registered
- overflow_err  out  1  sticky: a result arrived at a full source FIFO

## Operation
- FPU pipelines cannot stall; every src_valid is accepted unconditionally into FIFO i at the clock edge.
- Arrival at full FIFO i (after accounting for a same-cycle pop of i): entry dropped, overflow_err set, held until reset.
- Per-source FIFO preserves arrival order; no reordering within a channel.
- Arbitration each cycle over FIFO heads: scan from rr_ptr upward modulo N_SRC; first non-empty head → grant A, next non-empty head whose rt differs from A's rt → grant B. Head with rt equal to A's is skipped this cycle (no two same-rt writes in one cycle).
- Grant A drives the upper port, grant B the lower port; outputs registered. No grants → valid=0, rt/data hold previous values.
- rr_ptr update: one past the last granted index (B if present, else A), modulo N_SRC; unchanged if no grant.
- Granted heads pop at the same edge the output registers load.
- occupancy = sum of FIFO counts after this edge's push/pop; stall_out = (that sum ≥ STALL_THRESH).
- rt=0 results are written back like any other; register-file ignores r0.
- Reset: all FIFOs emptied (pending results discarded), rr_ptr=0, u/l_wb_valid=0, u/l_wb_rt=0, u/l_wb_data=0, stall_out=0, occupancy=0, overflow_err=0. Inputs ignored during reset cycles.

## Timing
- Arrival at edge t (src_valid high in cycle t-1→t), FIFO previously empty, no competition: wb_valid visible in cycle t+1 (one-cycle latency from input sample to output register)... precisely: input sampled edge t, granted in cycle after edge t, output visible after edge t+1 → 2 edges input-to-output.
- Throughput: 2 writebacks per cycle maximum; per-source 1 per cycle.
- stall_out and occupancy reflect state after the same edge; exec sees stall one cycle after occupancy crosses threshold. In-flight results keep arriving during stall; FDEPTH sized by the team's issue-rate guarantee.
- Simultaneous push and pop on same full FIFO: pop frees slot, push accepted, no error.

## Test plan
- Single result: src_valid[4]=1, rt=7, data=0x3F800000 one cycle → after two edges u_wb_valid=1, rt=7, data=0x3F800000; l_wb_valid=0; next cycle both 0.
- Two sources same cycle: ch0 rt=3 d=0x11, ch1 rt=5 d=0x22 → u port (3,0x11), l port (5,0x22) same cycle; rr_ptr=2.
- Same-rt conflict: ch2 and ch3 both rt=9 → cycle n u=(9,ch2 data), l invalid; cycle n+1 u=(9,ch3 data); register order matches channel scan.
- Burst of 6 channels in one cycle → occupancy=6, stall_out=1; drains 2/cycle in round-robin order over 3 cycles; stall_out drops when occupancy<4.
- Overflow: ch0 valid 3 consecutive cycles while ch1..ch13 continuously fed and rr_ptr starved ch0 → third ch0 dropped only if FIFO full; overflow_err=1, stays 1 until rstn=0.
- Reset mid-drain: occupancy=5, assert rstn=0 one cycle → all outputs 0, occupancy=0; no stale writeback after release.

Source files
------------

// File: rtl/fpu_wb_collector.sv
// Buffers FPU results per channel and writes up to two per cycle to the upper/lower regfile ports.
// Latency: 2 edges input-to-writeback; sources are never stalled, stall_out is advisory toward issue.

module fpu_wb_fifo #(
    parameter  int W     = 37,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdat_i,
    output logic [W-1:0]  rdat_o,
    output logic [CW-1:0] cnt_o,
    output logic [CW-1:0] cnt_nxt_o,
    output logic          ovf_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_pop    = pop_i && (cnt_q != '0);
    assign do_push   = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    assign ovf_o     = push_i && !do_push;
    assign cnt_nxt_o = cnt_q + CW'(do_push) - CW'(do_pop);
    assign rdat_o    = mem_q[rd_q];
    assign cnt_o     = cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_nxt_o;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdat_i;
    end
endmodule

module fpu_wb_collector #(
    parameter  int N_SRC        = 14,
    parameter  int FDEPTH       = 2,
    parameter  int STALL_THRESH = 4,
    localparam int OW           = $clog2(N_SRC*FDEPTH+1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_SRC-1:0]    src_valid,
    input  logic [5*N_SRC-1:0]  src_rt,
    input  logic [32*N_SRC-1:0] src_data,
    output logic                u_wb_valid,
    output logic [4:0]          u_wb_rt,
    output logic [31:0]         u_wb_data,
    output logic                l_wb_valid,
    output logic [4:0]          l_wb_rt,
    output logic [31:0]         l_wb_data,
    output logic                stall_out,
    output logic [OW-1:0]       occupancy,
    output logic                overflow_err
);
    localparam int IW = $clog2(N_SRC);
    localparam int CW = $clog2(FDEPTH+1);

    typedef struct packed {
        logic [4:0]  rt;
        logic [31:0] dat;
    } wb_ent_t;

    wb_ent_t          head    [N_SRC];
    logic [CW-1:0]    cnt     [N_SRC];
    logic [CW-1:0]    cnt_nxt [N_SRC];
    logic [N_SRC-1:0] pop, ovf;

    logic          gnt_a, gnt_b;
    logic [IW-1:0] a_idx, b_idx, rr_q, rr_d;
    logic [4:0]    a_rt;
    logic [OW-1:0] occ_d, occ_q;

    logic          u_vld_q, l_vld_q, stall_q, ovf_q;
    logic [4:0]    u_rt_q, l_rt_q;
    logic [31:0]   u_dat_q, l_dat_q;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        fpu_wb_fifo #(.W($bits(wb_ent_t)), .DEPTH(FDEPTH)) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .push_i    (src_valid[g]),
            .pop_i     (pop[g]),
            .wdat_i    ({src_rt[5*g +: 5], src_data[32*g +: 32]}),
            .rdat_o    (head[g]),
            .cnt_o     (cnt[g]),
            .cnt_nxt_o (cnt_nxt[g]),
            .ovf_o     (ovf[g])
        );
    end

    // Round-robin scan; the second grant must target a different register than the first.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_w;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        a_idx = '0;
        b_idx = '0;
        a_rt  = '0;
        pop   = '0;
        for (int off = 0; off < N_SRC; off++) begin
            idx = int'(rr_q) + off;
            if (idx >= N_SRC) idx = idx - N_SRC;
            idx_w = idx[IW-1:0];
            if (cnt[idx_w] != '0) begin
                if (!gnt_a) begin
                    gnt_a = 1'b1;
                    a_idx = idx_w;
                    a_rt  = head[idx_w].rt;
                end else if (!gnt_b && (head[idx_w].rt != a_rt)) begin
                    gnt_b = 1'b1;
                    b_idx = idx_w;
                end
            end
        end
        if (gnt_a) pop[a_idx] = 1'b1;
        if (gnt_b) pop[b_idx] = 1'b1;
    end

    always_comb begin
        int nxt;
        nxt = gnt_b ? int'(b_idx) + 1 : int'(a_idx) + 1;
        if (nxt >= N_SRC) nxt = 0;
        rr_d = gnt_a ? nxt[IW-1:0] : rr_q;
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < N_SRC; i++) occ_d = occ_d + OW'(cnt_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_q    <= '0;
            u_vld_q <= 1'b0;
            u_rt_q  <= '0;
            u_dat_q <= '0;
            l_vld_q <= 1'b0;
            l_rt_q  <= '0;
            l_dat_q <= '0;
            occ_q   <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            u_vld_q <= gnt_a;
            l_vld_q <= gnt_b;
            if (gnt_a) {u_rt_q, u_dat_q} <= head[a_idx];
            if (gnt_b) {l_rt_q, l_dat_q} <= head[b_idx];
            occ_q   <= occ_d;
            stall_q <= (occ_d >= OW'(STALL_THRESH));
            ovf_q   <= ovf_q | (|ovf);
        end
    end

    assign u_wb_valid   = u_vld_q;
    assign u_wb_rt      = u_rt_q;
    assign u_wb_data    = u_dat_q;
    assign l_wb_valid   = l_vld_q;
    assign l_wb_rt      = l_rt_q;
    assign l_wb_data    = l_dat_q;
    assign stall_out    = stall_q;
    assign occupancy    = occ_q;
    assign overflow_err = ovf_q;
endmodule

// File: tb/tb_fpu_wb_collector.sv
// Randomized and directed stimulus for fpu_wb_collector, checked every cycle against a queue-based model.
module tb_fpu_wb_collector;
    localparam int N      = 14;
    localparam int FDEPTH = 2;
    localparam int THRESH = 4;
    localparam int OW     = $clog2(N*FDEPTH+1);

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    src_valid;
    logic [5*N-1:0]  src_rt;
    logic [32*N-1:0] src_data;
    logic            u_wb_valid, l_wb_valid, stall_out, overflow_err;
    logic [4:0]      u_wb_rt, l_wb_rt;
    logic [31:0]     u_wb_data, l_wb_data;
    logic [OW-1:0]   occupancy;

    fpu_wb_collector #(.N_SRC(N), .FDEPTH(FDEPTH), .STALL_THRESH(THRESH)) dut (
        .clk(clk), .rstn(rstn), .src_valid(src_valid), .src_rt(src_rt), .src_data(src_data),
        .u_wb_valid(u_wb_valid), .u_wb_rt(u_wb_rt), .u_wb_data(u_wb_data),
        .l_wb_valid(l_wb_valid), .l_wb_rt(l_wb_rt), .l_wb_data(l_wb_data),
        .stall_out(stall_out), .occupancy(occupancy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one queue per channel of {rt, data}.
    logic [36:0] q [N][$];
    int          rr;
    logic        e_uv, e_lv, e_stall, e_ovf;
    logic [4:0]  e_urt, e_lrt;
    logic [31:0] e_ud, e_ld;
    int          e_occ;

    task automatic model_step();
        int ga, gb, i, tot;
        logic [36:0] ent;
        if (!rstn) begin
            for (int c = 0; c < N; c++) q[c].delete();
            rr = 0; e_uv = 0; e_lv = 0; e_urt = 0; e_lrt = 0; e_ud = 0; e_ld = 0;
            e_occ = 0; e_stall = 0; e_ovf = 0;
            return;
        end
        ga = -1; gb = -1;
        for (int off = 0; off < N; off++) begin
            i = (rr + off) % N;
            if (q[i].size() > 0) begin
                if (ga < 0) ga = i;
                else if (gb < 0 && q[i][0][36:32] != q[ga][0][36:32]) gb = i;
            end
        end
        e_uv = (ga >= 0);
        e_lv = (gb >= 0);
        if (ga >= 0) begin ent = q[ga].pop_front(); e_urt = ent[36:32]; e_ud = ent[31:0]; end
        if (gb >= 0) begin ent = q[gb].pop_front(); e_lrt = ent[36:32]; e_ld = ent[31:0]; end
        if (gb >= 0) rr = (gb + 1) % N;
        else if (ga >= 0) rr = (ga + 1) % N;
        for (int c = 0; c < N; c++) begin
            if (src_valid[c]) begin
                if (q[c].size() < FDEPTH) q[c].push_back({src_rt[5*c +: 5], src_data[32*c +: 32]});
                else e_ovf = 1;
            end
        end
        tot = 0;
        for (int c = 0; c < N; c++) tot += q[c].size();
        e_occ = tot;
        e_stall = (tot >= THRESH);
    endtask

    task automatic compare_all();
        check_eq("u_wb_valid", u_wb_valid, e_uv);
        check_eq("u_wb_rt", u_wb_rt, e_urt);
        check_eq("u_wb_data", u_wb_data, e_ud);
        check_eq("l_wb_valid", l_wb_valid, e_lv);
        check_eq("l_wb_rt", l_wb_rt, e_lrt);
        check_eq("l_wb_data", l_wb_data, e_ld);
        check_eq("occupancy", occupancy, e_occ);
        check_eq("stall_out", stall_out, e_stall);
        check_eq("overflow_err", overflow_err, e_ovf);
    endtask

    // Inputs are set between negedge and posedge; outputs compared on the following negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clr_in();
        src_valid = '0; src_rt = '0; src_data = '0;
    endtask

    task automatic put(input int ch, input logic [4:0] rt, input logic [31:0] d);
        src_valid[ch] = 1'b1;
        src_rt[5*ch +: 5] = rt;
        src_data[32*ch +: 32] = d;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clr_in();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        clr_in();
        @(negedge clk);
        do_reset();
        check_eq("rst_occupancy", occupancy, 0);
        check_eq("rst_u_valid", u_wb_valid, 0);

        // Single result on channel 4
        put(4, 5'd7, 32'h3F800000);
        tick();
        clr_in();
        tick();
        check_eq("single_u_valid", u_wb_valid, 1);
        check_eq("single_u_rt", u_wb_rt, 7);
        check_eq("single_u_data", u_wb_data, 32'h3F800000);
        check_eq("single_l_valid", l_wb_valid, 0);
        tick();
        check_eq("single_after_u", u_wb_valid, 0);

        // Two sources, distinct rt, same cycle
        put(0, 5'd3, 32'h11); put(1, 5'd5, 32'h22);
        tick();
        clr_in();
        tick();
        check_eq("pair_u_rt", u_wb_rt, 3);
        check_eq("pair_u_data", u_wb_data, 32'h11);
        check_eq("pair_l_valid", l_wb_valid, 1);
        check_eq("pair_l_rt", l_wb_rt, 5);
        check_eq("pair_l_data", l_wb_data, 32'h22);

        // Same-rt conflict: ch2 first, ch3 next cycle
        put(2, 5'd9, 32'hA2); put(3, 5'd9, 32'hA3);
        tick();
        clr_in();
        tick();
        check_eq("conf_u_data0", u_wb_data, 32'hA2);
        check_eq("conf_l_valid0", l_wb_valid, 0);
        tick();
        check_eq("conf_u_valid1", u_wb_valid, 1);
        check_eq("conf_u_data1", u_wb_data, 32'hA3);

        // Burst on six channels
        for (int c = 4; c < 10; c++) put(c, 5'(c + 10), 32'hB0 + 32'(c));
        tick();
        clr_in();
        check_eq("burst_occ", occupancy, 6);
        check_eq("burst_stall", stall_out, 1);
        tick();
        check_eq("burst_u_data", u_wb_data, 32'hB4);
        check_eq("burst_l_data", l_wb_data, 32'hB5);
        tick();
        check_eq("burst_stall_drop", stall_out, 0);
        tick();
        check_eq("burst_occ_empty", occupancy, 0);

        // Overflow: every channel fed for three cycles
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < N; c++) put(c, 5'(c), 32'(k * 100 + c));
            tick();
        end
        clr_in();
        check_eq("ovf_set", overflow_err, 1);
        for (int k = 0; k < 20; k++) tick();
        check_eq("ovf_sticky", overflow_err, 1);
        do_reset();
        check_eq("ovf_cleared", overflow_err, 0);

        // Reset mid-drain
        for (int c = 0; c < 5; c++) put(c, 5'(c + 1), 32'hC0 + 32'(c));
        tick();
        clr_in();
        check_eq("mid_occ", occupancy, 5);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_eq("mid_rst_occ", occupancy, 0);
        check_eq("mid_rst_u_data", u_wb_data, 0);
        tick();
        tick();
        check_eq("mid_no_stale", u_wb_valid, 0);

        // Random phases with small rt range to provoke conflicts and occasional overflow
        for (int ph = 0; ph < 4; ph++) begin
            do_reset();
            for (int cyc = 0; cyc < 400; cyc++) begin
                clr_in();
                for (int c = 0; c < N; c++)
                    if ($urandom_range(7 + ph * 2) == 0) put(c, 5'($urandom_range(3)), $urandom);
                if ($urandom_range(199) == 0) rstn = 1'b0;
                tick();
                rstn = 1'b1;
            end
            clr_in();
            for (int k = 0; k < 20; k++) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
